// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage handshake state and per-stage payload structs.
// Payload structs are cast to a flat WIDTH vector when a generic stage register is instantiated.
package cpu_types_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 4;

  // Occupancy of an elastic stage register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_val;
    logic [XLEN-1:0]    rs2_val;
    logic [XLEN-1:0]    imm;
    logic [REG_AW-1:0]  rd;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_rd;
    logic               mem_wr;
    logic               reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   store_val;
    logic [REG_AW-1:0] rd;
    logic              mem_rd;
    logic              mem_wr;
    logic              reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]   wb_val;
    logic [REG_AW-1:0] rd;
    logic              reg_wr;
  } mem_wb_t;

  localparam int unsigned IF_ID_W  = $bits(if_id_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Reusable for any performance event counter.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Generic elastic pipeline stage register: valid/ready handshake, one-entry skid buffer,
// synchronous flush to a bubble value, external freeze and a back-pressure cycle counter.
module pipeline_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int unsigned      WIDTH     = 128,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             freeze,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_v_q;
  logic             rdy_q;
  logic             in_fire_c;
  logic             out_fire_c;
  logic             stall_inc_c;
  logic             stall_clr_c;

  // rdy_q mirrors (state != FULL) so the ready path starts at a flop.
  assign in_ready   = rdy_q & ~freeze & ~flush;
  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = main_v_q & out_ready & ~freeze & ~flush;

  assign out_valid = main_v_q;
  assign out_data  = main_q;

  // Next-state and datapath select; flush overrides freeze.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else if (!freeze) begin
      case (state_q)
        EMPTY: begin
          if (in_fire_c) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire_c && out_fire_c) begin
            main_d = in_data;
          end else if (in_fire_c) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire_c) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= EMPTY;
      main_q   <= NOP_VALUE;
      skid_q   <= NOP_VALUE;
      main_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= (state_d != EMPTY);
      rdy_q    <= (state_d != FULL);
    end
  end

  // Back-pressure: a beat is presented but downstream refuses it; freeze holds the count.
  assign stall_inc_c = main_v_q & ~out_ready & ~freeze;
  assign stall_clr_c = cnt_clr & ~freeze;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc_c),
    .clr   (stall_clr_c),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: vector table, hand-written corner sequences,
// and an in-order scoreboard fed by observed input/output handshakes.
module tb_pipeline_stage_reg;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;
  localparam logic [W-1:0] NOP = 16'hBEEF;

  logic          CLK;
  logic          nRST;
  logic          flush;
  logic          freeze;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          cnt_clr;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  typedef struct {
    logic         fl;
    logic         fz;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         clr;
    logic         exp_ir;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    logic [CW-1:0] exp_sc;
  } vec_t;

  vec_t vq[$];

  pipeline_stage_reg #(
    .WIDTH     (W),
    .NOP_VALUE (NOP),
    .CNT_W     (CW)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic fz, input logic iv, input logic [W-1:0] d,
                              input logic ordy, input logic clr, input logic ir, input logic ov,
                              input logic [W-1:0] od, input logic [CW-1:0] sc);
    vec_t v;
    v.fl = fl; v.fz = fz; v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_sc = sc;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic fl, input logic fz, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic clr);
    flush = fl; freeze = fz; in_valid = iv; in_data = d; out_ready = ordy; cnt_clr = clr;
  endtask

  // Scoreboard: inputs are stable from just after one rising edge to the next, so the
  // falling edge shows exactly what the DUT will act on at the following rising edge.
  always @(negedge CLK) begin
    if (!nRST) begin
      sb.delete();
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && !freeze) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("sb_order", 32'(out_data), 32'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    nRST = 1'b0;
    drive(0, 0, 0, '0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'(NOP));
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // streaming 1..8 with out_ready high
    for (int i = 1; i <= 8; i++) vq.push_back(mk(0, 0, 1, W'(i), 1, 0, 1, 1, W'(i), 0));
    vq.push_back(mk(0, 0, 0, 16'h0,  1, 0, 1, 0, 16'h8,  0));
    // back-pressure into FULL, then drain
    vq.push_back(mk(0, 0, 1, 16'hA,  0, 0, 1, 1, 16'hA,  0));
    vq.push_back(mk(0, 0, 1, 16'hB,  0, 0, 1, 1, 16'hA,  1));
    vq.push_back(mk(0, 0, 0, 16'h0,  0, 0, 0, 1, 16'hA,  2));
    vq.push_back(mk(0, 0, 0, 16'h0,  0, 0, 0, 1, 16'hA,  3));
    vq.push_back(mk(0, 0, 0, 16'h0,  1, 0, 0, 1, 16'hB,  3));
    vq.push_back(mk(0, 0, 0, 16'h0,  1, 0, 1, 0, 16'hB,  3));
    vq.push_back(mk(0, 0, 0, 16'h0,  0, 1, 1, 0, 16'hB,  0));
    // flush from FULL with a beat offered; the beat is taken afterwards
    vq.push_back(mk(0, 0, 1, 16'h11, 0, 0, 1, 1, 16'h11, 0));
    vq.push_back(mk(0, 0, 1, 16'h12, 0, 0, 1, 1, 16'h11, 1));
    vq.push_back(mk(1, 0, 1, 16'hC,  0, 0, 0, 0, NOP,    2));
    vq.push_back(mk(0, 0, 1, 16'hC,  0, 0, 1, 1, 16'hC,  2));
    vq.push_back(mk(0, 0, 0, 16'h0,  1, 0, 1, 0, 16'hC,  2));
    // freeze for 4 cycles in ONE with both sides willing
    vq.push_back(mk(0, 0, 1, 16'h21, 0, 0, 1, 1, 16'h21, 2));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 1, 1, 16'h22, 1, 0, 0, 1, 16'h21, 2));
    vq.push_back(mk(0, 0, 1, 16'h22, 1, 0, 1, 1, 16'h22, 2));
    vq.push_back(mk(0, 0, 0, 16'h0,  1, 0, 1, 0, 16'h22, 2));

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].fz, vq[i].iv, vq[i].d, vq[i].ordy, vq[i].clr);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vq[i].exp_ir));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].exp_ov));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vq[i].exp_od));
      chk($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(vq[i].exp_sc));
    end

    // counter saturation at 2^CW-1, then clear
    drive(0, 0, 0, '0, 0, 1);
    tick();
    chk("sat_pre_clr", 32'(stall_cnt), 32'd0);
    drive(0, 0, 1, 16'h55, 0, 0);
    tick();
    chk("sat_load_valid", 32'(out_valid), 32'd1);
    chk("sat_load_data", 32'(out_data), 32'h55);
    drive(0, 0, 0, '0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", k), 32'(stall_cnt), (k > 15) ? 32'd15 : 32'(k));
    end
    drive(0, 0, 0, '0, 0, 1);
    tick();
    chk("sat_clr", 32'(stall_cnt), 32'd0);
    drive(0, 0, 0, '0, 1, 0);
    tick();
    chk("sat_drain", 32'(out_valid), 32'd0);

    // asynchronous reset while FULL
    drive(0, 0, 1, 16'h61, 0, 0);
    tick();
    drive(0, 0, 1, 16'h62, 0, 0);
    tick();
    chk("prerst_full", 32'(in_ready), 32'd0);
    drive(0, 0, 0, '0, 0, 0);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data",  32'(out_data),  32'(NOP));
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    nRST = 1'b1;
    drive(0, 0, 1, 16'h77, 0, 0);
    tick();
    chk("postrst_valid", 32'(out_valid), 32'd1);
    chk("postrst_data",  32'(out_data),  32'h77);
    drive(0, 0, 0, '0, 1, 0);
    tick();
    chk("postrst_drain", 32'(out_valid), 32'd0);
    drive(0, 0, 0, '0, 0, 0);
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
# pipeline_stage_reg

Parametrised, elastic pipeline stage register that replaces fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries an opaque WIDTH-bit payload with a valid/ready handshake, a one-entry skid buffer so that `in_ready` is registered, synchronous flush to a configurable bubble value, and an external freeze. A saturating counter records back-pressure cycles for performance debug.

## Interface
- `WIDTH`, 128: payload width in bits; must be at least 1.
- `NOP_VALUE`, '0: payload value loaded on reset or flush; the bubble pattern.
- `CNT_W`, 16: stall counter width.
- `CLK` input 1: single clock, rising edge.
- `nRST` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous squash of all held entries.
- `freeze` input 1: hold all state; no handshake completes.
- `in_valid` input 1: upstream offers a beat.
- `in_data` input WIDTH: upstream payload.
- `in_ready` output 1: stage accepts a beat this cycle.
- `out_valid` output 1: stage presents a beat.
- `out_data` output WIDTH: presented payload, taken from the main register.
- `out_ready` input 1: downstream accepts.
- `cnt_clr` input 1: synchronous clear of `stall_cnt`.
- `stall_cnt` output CNT_W: saturating count of back-pressure cycles.

## Operation
- Storage: main register (`main_q`, `main_v`) drives the outputs. Skid register (`skid_q`) is used only in state FULL.
- Handshake terms:
  - `in_ready = (state != FULL) & !freeze & !flush`
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready & !freeze & !flush`
- States (`stage_state_t`): EMPTY, ONE, FULL. `out_valid = (state != EMPTY)`.
- EMPTY:
  - `in_fire` → ONE; `main_q` ← `in_data`.
- ONE:
  - `in_fire` and `out_fire` → ONE; `main_q` ← `in_data`.
  - `in_fire` only → FULL; `skid_q` ← `in_data`.
  - `out_fire` only → EMPTY; `main_q` holds its value.
- FULL:
  - `out_fire` → ONE; `main_q` ← `skid_q`.
  - No `in_fire` is possible in FULL.
- Priority, highest first:
  1. `nRST` low: EMPTY; `main_q` and `skid_q` = NOP_VALUE; `stall_cnt` = 0.
  2. `flush`: next state EMPTY; `main_q` and `skid_q` = NOP_VALUE. Concurrent `in_valid` is not accepted because `in_ready` is 0.
  3. `freeze`: all state holds, including `stall_cnt`.
  4. Normal transitions as listed above.
- Ordering: beats leave in the order they arrived; none is dropped or duplicated.
- `stall_cnt`:
  - Increments when `out_valid & !out_ready & !freeze`.
  - Saturates at 2^CNT_W−1.
  - `cnt_clr` forces it to 0 and takes priority over increment.
  - `flush` does not clear it.

## Timing
- Latency: 1 cycle from `in_fire` to `out_valid`/`out_data` on an empty stage.
- Throughput: 1 beat per cycle while `out_ready` is held high.
- `out_valid`, `out_data` and `stall_cnt` are pure flop outputs.
- `in_ready` is registered state, gated combinationally only by `freeze` and `flush`.
- Reset values: `out_valid` 0, `out_data` NOP_VALUE, `in_ready` 1 (when `freeze` and `flush` are low), `stall_cnt` 0.
- Reset may assert at any cycle. On deassertion the first accept can occur on the next rising edge.
- Upstream must hold `in_valid`/`in_data` stable until `in_fire`; downstream has the same obligation on the output side.

## Structure
- `cpu_types_pkg` gains `stage_state_t` (2-bit enum EMPTY/ONE/FULL).
- Stage-specific payload structs live in `cpu_types_pkg` and are cast to WIDTH at instantiation. The block is payload-agnostic.
- Sub-module `sat_counter` (parameter CNT_W; inputs `inc`, `clr`; output `count`) implements `stall_cnt` and is reusable by other perf counters.
- Estimated size: about 150 lines of RTL plus about 40 for `sat_counter`.

## Test plan
- **Reset:** `nRST` low mid-stream with FULL state → `out_valid` 0, `out_data` NOP_VALUE, `in_ready` 1, `stall_cnt` 0.
- **Streaming:** 8 beats 0x1..0x8 with `out_ready` held 1 → emerge one cycle later, one per cycle, in order; `stall_cnt` stays 0.
- **Back-pressure:**
  - Send 0xA, 0xB with `out_ready` 0 → state FULL, `in_ready` 0, `out_data` 0xA; after 3 cycles `stall_cnt` = 3.
  - Raise `out_ready` → 0xA then 0xB are delivered.
- **Flush:** flush in FULL with `in_valid` 1 (0xC) → next cycle EMPTY, `out_data` NOP_VALUE; 0xC is not accepted (`in_ready` was 0) and is sent after flush.
- **Freeze:** freeze for 4 cycles in state ONE with `out_ready` 1 and `in_valid` 1 → nothing moves, `stall_cnt` unchanged; on release, delivery resumes.
- **Counter saturation:** CNT_W = 4, hold back-pressure for 20 cycles → `stall_cnt` = 15; `cnt_clr` → 0 on the next cycle.
